// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms on a rising clock/alarm match, rings, snoozes,
// auto-silences after a timeout and re-rings after each snooze interval.
module alarm_sequencer #(
  parameter int RING_MIN   = 5,
  parameter int SNOOZE_MIN = 9,
  parameter int MAX_SNOOZE = 3,
  parameter int CW         = 4
) (
  input  logic          ck,
  input  logic          reset,
  input  logic          sec,
  input  logic          min,
  input  logic          enable,
  input  logic          match,
  input  logic          snooze,
  input  logic          stop,
  output logic          ring,
  output logic          blink,
  output logic          snoozing,
  output logic [CW-1:0] snooze_left,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [CW-1:0] RING_LAST = CW'(RING_MIN - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(SNOOZE_MIN - 1);
  localparam logic [CW-1:0] LEFT_INIT = CW'(MAX_SNOOZE);

  state_e        state_q, state_d;
  logic [CW-1:0] ring_cnt_q, ring_cnt_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] left_q, left_d;
  logic          blink_q, blink_d;
  logic          snooze_q, stop_q, match_q;

  logic snooze_rise, stop_rise, match_rise;

  assign snooze_rise = snooze & ~snooze_q;
  assign stop_rise   = stop & ~stop_q;
  assign match_rise  = match & ~match_q;

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    wait_cnt_d = wait_cnt_q;
    left_d     = left_q;
    blink_d    = blink_q;
    unique case (state_q)
      IDLE: begin
        if (enable && match_rise) begin
          state_d    = RING;
          ring_cnt_d = '0;
          left_d     = LEFT_INIT;
          blink_d    = 1'b0;
        end
      end
      RING: begin
        if (!enable) begin
          state_d = IDLE;
          blink_d = 1'b0;
        end else if (stop_rise) begin
          state_d = DONE;
          blink_d = 1'b0;
        end else if (snooze_rise && left_q != '0) begin
          state_d    = SNOOZE;
          left_d     = left_q - 1'b1;
          wait_cnt_d = '0;
          blink_d    = 1'b0;
        end else if (min && ring_cnt_q == RING_LAST) begin
          state_d = DONE;
          blink_d = 1'b0;
        end else begin
          if (min) ring_cnt_d = ring_cnt_q + 1'b1;
          if (sec) blink_d = ~blink_q;
        end
      end
      SNOOZE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (stop_rise) begin
          state_d = DONE;
        end else if (min) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = RING;
            ring_cnt_d = '0;
            blink_d    = 1'b0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Held until the matching minute ends, so it cannot re-ring
        if (!enable || !match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      wait_cnt_q <= '0;
      left_q     <= LEFT_INIT;
      blink_q    <= 1'b0;
      snooze_q   <= 1'b0;
      stop_q     <= 1'b0;
      match_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      left_q     <= left_d;
      blink_q    <= blink_d;
      snooze_q   <= snooze;
      stop_q     <= stop;
      match_q    <= match;
    end
  end

  assign ring        = (state_q == RING);
  assign snoozing    = (state_q == SNOOZE);
  assign blink       = blink_q;
  assign snooze_left = left_q;
  assign state       = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: event-level model checked every cycle,
// plus directed literal expectations.
module tb_alarm_sequencer;

  localparam int RING_MIN   = 5;
  localparam int SNOOZE_MIN = 9;
  localparam int MAX_SNOOZE = 3;
  localparam int CW         = 4;

  logic          ck = 1'b0;
  logic          reset = 1'b1;
  logic          sec = 1'b0;
  logic          min = 1'b0;
  logic          enable = 1'b0;
  logic          match = 1'b0;
  logic          snooze = 1'b0;
  logic          stop = 1'b0;
  logic          ring, blink, snoozing;
  logic [CW-1:0] snooze_left;
  logic [1:0]    state;

  int total = 0;
  int passed = 0;

  alarm_sequencer #(
    .RING_MIN(RING_MIN), .SNOOZE_MIN(SNOOZE_MIN),
    .MAX_SNOOZE(MAX_SNOOZE), .CW(CW)
  ) dut (
    .ck(ck), .reset(reset), .sec(sec), .min(min),
    .enable(enable), .match(match), .snooze(snooze), .stop(stop),
    .ring(ring), .blink(blink), .snoozing(snoozing),
    .snooze_left(snooze_left), .state(state)
  );

  always #5 ck = ~ck;

  // Model: mode 0 idle, 1 ringing, 2 snoozing, 3 silenced
  int m_mode, m_rang, m_waited, m_left;
  bit m_blink, p_snz, p_stp, p_match, started;

  always @(posedge ck) begin
    bit sr, st, mr;
    sr = snooze && !p_snz;
    st = stop && !p_stp;
    mr = match && !p_match;
    if (reset) begin
      m_mode = 0; m_rang = 0; m_waited = 0;
      m_left = MAX_SNOOZE; m_blink = 0;
      p_snz = 0; p_stp = 0; p_match = 1;
    end else begin
      if (m_mode == 0) begin
        if (enable && mr) begin
          m_mode = 1; m_rang = 0; m_left = MAX_SNOOZE; m_blink = 0;
        end
      end else if (m_mode == 1) begin
        if (!enable) m_mode = 0;
        else if (st) m_mode = 3;
        else if (sr && m_left > 0) begin
          m_mode = 2; m_left--; m_waited = 0;
        end else if (min && m_rang + 1 >= RING_MIN) m_mode = 3;
        else begin
          m_rang += int'(min);
          if (sec) m_blink = !m_blink;
        end
        if (m_mode != 1) m_blink = 0;
      end else if (m_mode == 2) begin
        if (!enable) m_mode = 0;
        else if (st) m_mode = 3;
        else if (min) begin
          m_waited++;
          if (m_waited >= SNOOZE_MIN) begin
            m_mode = 1; m_rang = 0; m_blink = 0;
          end
        end
      end else begin
        if (!enable || !match) m_mode = 0;
      end
      p_snz = snooze; p_stp = stop; p_match = match;
    end
    started = 1;
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge ck) begin
    if (started) begin
      int exp_v, act_v;
      exp_v = {m_blink, m_mode == 1, m_mode == 2, 4'(m_left), 2'(m_mode)};
      act_v = {blink, ring, snoozing, snooze_left, state};
      chk($sformatf("cycle t=%0t {blink,ring,snz,left,state}", $time),
          act_v, exp_v);
    end
  end

  task automatic clk1();
    @(posedge ck);
    #1;
  endtask

  task automatic pulse_sec();
    sec = 1; clk1(); sec = 0; clk1();
  endtask

  task automatic pulse_min(int n);
    for (int i = 0; i < n; i++) begin
      min = 1; clk1(); min = 0; clk1();
    end
  endtask

  task automatic press_snooze();
    snooze = 1; clk1(); snooze = 0; clk1();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clk1(); clk1();
    chk("reset state", state, 0);
    chk("reset left", snooze_left, 3);
    chk("reset ring", ring, 0);
    reset = 0; enable = 1; clk1();
    match = 1; clk1();
    chk("arm state", state, 1);
    chk("arm ring", ring, 1);
    pulse_sec(); chk("blink1", blink, 1);
    pulse_sec(); chk("blink2", blink, 0);
    pulse_sec(); chk("blink3", blink, 1);

    snooze = 1; clk1();
    chk("snz state", state, 2);
    chk("snz snoozing", snoozing, 1);
    chk("snz ring", ring, 0);
    chk("snz left", snooze_left, 2);
    snooze = 0; clk1();
    pulse_min(8); chk("snz 8min", state, 2);
    pulse_min(1);
    chk("rering state", state, 1);
    chk("rering blink", blink, 0);

    press_snooze(); pulse_min(9);
    press_snooze(); pulse_min(9);
    chk("left zero", snooze_left, 0);
    chk("ring again", state, 1);
    press_snooze();
    chk("4th snooze ignored", state, 1);
    pulse_min(4); chk("ring 4min", state, 1);
    pulse_min(1); chk("timeout done", state, 3);
    match = 0; clk1();
    chk("match low idle", state, 0);

    match = 1; clk1(); chk("rise rings", ring, 1);
    stop = 1; clk1();
    chk("stop done", state, 3);
    chk("stop ring", ring, 0);
    stop = 0; clk1();
    pulse_min(10); chk("no rering", state, 3);
    match = 0; clk1(); chk("done->idle", state, 0);
    match = 1; clk1(); chk("rering rise", ring, 1);

    press_snooze(); chk("snz2", state, 2);
    enable = 0; clk1();
    chk("disable idle", state, 0);
    chk("disable snoozing", snoozing, 0);
    enable = 1; clk1(); clk1();
    chk("enable mid match", state, 0);

    match = 0; clk1(); match = 1; clk1();
    chk("ring3", state, 1);
    pulse_min(4);
    snooze = 1; min = 1; clk1();
    chk("snooze beats timeout", state, 2);
    snooze = 0; min = 0; clk1();
    pulse_min(9); chk("back to ring", state, 1);
    snooze = 1; stop = 1; clk1();
    chk("stop beats snooze", state, 3);
    chk("stop beats snooze left", snooze_left, 2);
    snooze = 0; stop = 0;
    match = 0; clk1(); match = 1; clk1();
    pulse_sec(); chk("ring4 blink", blink, 1);
    reset = 1; clk1();
    chk("mid reset state", state, 0);
    chk("mid reset left", snooze_left, 3);
    chk("mid reset blink", blink, 0);
    reset = 0; clk1(); clk1();
    chk("no ring after reset", state, 0);
    match = 0; clk1(); match = 1; clk1();
    chk("ring after re-rise", ring, 1);
    clk1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
